// File: rtl/intersection_sensor_frontend_if.sv
// intersection_sensor_frontend_if: field-side bundle between raw sensors and the conditioned outputs
// master: drives cam_raw/vip_req, receives traffic_camera/isvip/vip_path_index
// slave : the frontend, receives raw inputs and drives the conditioned outputs
interface intersection_sensor_frontend_if;
    logic [1:0] cam_raw;
    logic [1:0] vip_req;
    logic [1:0] traffic_camera;
    logic       isvip;
    logic       vip_path_index;
    modport master (output cam_raw, vip_req, input traffic_camera, isvip, vip_path_index);
    modport slave  (input cam_raw, vip_req, output traffic_camera, isvip, vip_path_index);
endinterface

// File: rtl/intersection_sensor_frontend.sv
// intersection_sensor_frontend: camera debounce plus confirmed, arbitrated VIP beacon grant
// clk, rst           : rising-edge clock, synchronous active-high reset
// bus.cam_raw[1:0]   : raw camera detect per path     -> bus.traffic_camera[1:0] (debounced)
// bus.vip_req[1:0]   : beacon request level per path  -> bus.isvip / bus.vip_path_index
module intersection_sensor_frontend #(
    parameter int DEB_CYCLES   = 4,
    parameter int VIP_CONFIRM  = 3,
    parameter int VIP_MIN      = 10,
    parameter int VIP_MAX      = 40,
    parameter int VIP_COOLDOWN = 8
) (
    input logic clk,
    input logic rst,
    intersection_sensor_frontend_if.slave bus
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int CW   = $clog2(VIP_CONFIRM + 1);
    localparam int HTOP = VIP_MAX > VIP_COOLDOWN ? VIP_MAX : VIP_COOLDOWN;
    localparam int HW   = $clog2(HTOP + 1);
    typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;
    state_t          state;
    logic [DW-1:0]   deb_cnt [2];
    logic [CW-1:0]   conf [2];
    logic [HW-1:0]   hold_cnt;
    logic [1:0]      cam_q;
    logic            vip_q;
    logic            idx_q;
    logic            last_grant;
    logic [1:0]      hit;
    logic            pick;
    assign bus.traffic_camera = cam_q;
    assign bus.isvip          = vip_q;
    assign bus.vip_path_index = idx_q;
    always_comb begin
        hit[0] = bus.vip_req[0] && conf[0] == CW'(VIP_CONFIRM - 1);
        hit[1] = bus.vip_req[1] && conf[1] == CW'(VIP_CONFIRM - 1);
        // simultaneous confirmation alternates against the previous winner
        pick = &hit ? ~last_grant : hit[1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cam_q <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.cam_raw[i] != cam_q[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        cam_q[i]   <= bus.cam_raw[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vip_q      <= 1'b0;
            idx_q      <= 1'b0;
            last_grant <= 1'b1;
            hold_cnt   <= '0;
            conf[0]    <= '0;
            conf[1]    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|hit) begin
                        vip_q      <= 1'b1;
                        idx_q      <= pick;
                        last_grant <= pick;
                        hold_cnt   <= '0;
                        conf[0]    <= '0;
                        conf[1]    <= '0;
                        state      <= GRANT;
                    end else begin
                        conf[0] <= bus.vip_req[0] ? conf[0] + 1'b1 : '0;
                        conf[1] <= bus.vip_req[1] ? conf[1] + 1'b1 : '0;
                    end
                end
                GRANT: begin
                    // the max cap wins over an ongoing request; the other path cannot pre-empt
                    if (hold_cnt == HW'(VIP_MAX - 1) ||
                        (hold_cnt >= HW'(VIP_MIN - 1) && !bus.vip_req[idx_q])) begin
                        vip_q    <= 1'b0;
                        hold_cnt <= '0;
                        state    <= COOLDOWN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (hold_cnt == HW'(VIP_COOLDOWN - 1)) begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
